// File: rtl/digest_stream.sv
// Digest output stage: latches the final H register bank and streams the truncated
// digest as big-endian 32-bit words, H0 first, over a valid/ready handshake.
module digest_stream #(
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sha_type,
    input  logic [511:0]     h_in,
    input  logic             capture,
    output logic             busy,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [511:0]     h_q, h_d;
    logic [1:0]       type_q, type_d;
    logic [OUT_W-1:0] hold_q, hold_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;

    logic [3:0]       last_idx;
    logic [3:0]       sel;
    logic [OUT_W-1:0] word;
    logic             hs;
    logic             last_hs;
    logic             accept;

    always_comb begin
        unique case (type_q)
            2'b00:   last_idx = 4'd6;
            2'b01:   last_idx = 4'd7;
            2'b10:   last_idx = 4'd11;
            default: last_idx = 4'd15;
        endcase
    end

    // h_q viewed as sixteen 32-bit slots, slot 0 at the MSB; 32-bit modes use even slots only.
    assign sel = type_q[1] ? idx_q : {idx_q[2:0], 1'b0};

    always_comb begin
        word = h_q[511 -: 32];
        for (int j = 0; j < 16; j++) begin
            if (sel == 4'(j)) begin
                word = h_q[511 - 32 * j -: 32];
            end
        end
    end

    assign hs      = (state_q == StStream) && dout_ready;
    assign last_hs = hs && (idx_q == last_idx);
    // A capture is only taken when nothing is in flight after this edge.
    assign accept  = capture && ((state_q == StIdle) || last_hs);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            h_q     <= '0;
            type_q  <= 2'b00;
            hold_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            h_q     <= h_d;
            type_q  <= type_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        h_d     = h_q;
        type_d  = type_q;
        hold_d  = hold_q;
        done_d  = last_hs;
        ovr_d   = capture && (state_q == StStream) && !last_hs;

        if (hs) begin
            hold_d = word;
            if (!last_hs) begin
                idx_d = idx_q + 4'd1;
            end
        end
        if (last_hs) begin
            state_d = StIdle;
        end
        if (accept) begin
            state_d = StStream;
            idx_d   = 4'd0;
            h_d     = h_in;
            type_d  = sha_type;
        end
    end

    // Outputs
    always_comb begin
        busy       = (state_q == StStream);
        dout_valid = (state_q == StStream);
        dout_last  = (state_q == StStream) && (idx_q == last_idx);
        dout       = (state_q == StStream) ? word : hold_q;
        done       = done_q;
        overrun    = ovr_q;
    end

endmodule

// File: tb/tb_digest_stream.sv
// Directed bench for digest_stream: known SHA "abc" digests, stalls, overrun,
// capture on the final handshake and mid-stream reset.
module tb_digest_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   sha_type;
    logic [511:0] h_in;
    logic         capture;
    logic         busy;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic         done;
    logic         overrun;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0]  exp_w [16];
    logic [511:0] h256, h224, h512;

    localparam logic [31:0] A5 = 32'ha5a5a5a5;

    digest_stream #(.OUT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .sha_type   (sha_type),
        .h_in       (h_in),
        .capture    (capture),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [511:0] h, input logic [1:0] t);
        h_in     = h;
        sha_type = t;
        capture  = 1'b1;
        tick();
        capture  = 1'b0;
        h_in     = {16{32'h0badf00d}};
        sha_type = ~t;
    endtask

    // Handshakes words start..stop-1; when stop==n also checks the tail (done, idle, hold).
    task automatic run_stream(input int start, input int stop, input int n, input int mode);
        int k = start;
        int cyc = 0;
        logic stall = 1'b0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        while (k < stop && cyc < 200) begin
            check($sformatf("valid%0d", k), dout_valid, 1);
            check($sformatf("busy%0d", k), busy, 1);
            if (stall) begin
                check($sformatf("stable%0d", k), dout, pd);
                check($sformatf("stable_last%0d", k), dout_last, pl);
            end
            dout_ready = (mode != 0) ? ((cyc % 3) != 1) : 1'b1;
            if (dout_ready) begin
                check($sformatf("word%0d", k), dout, exp_w[k]);
                check($sformatf("last%0d", k), dout_last, (k == n - 1));
                k++;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
                pd    = dout;
                pl    = dout_last;
            end
            cyc++;
            tick();
        end
        check("stream_count", k, stop);
        if (stop == n) begin
            dout_ready = 1'b1;
            check("done_pulse", done, 1);
            check("idle_valid", dout_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_last", dout_last, 0);
            check("idle_hold", dout, exp_w[n - 1]);
            tick();
            check("done_end", done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        h256 = {32'hba7816bf, A5, 32'h8f01cfea, A5, 32'h414140de, A5, 32'h5dae2223, A5,
                32'hb00361a3, A5, 32'h96177a9c, A5, 32'hb410ff61, A5, 32'hf20015ad, A5};
        h224 = {32'h23097d22, A5, 32'h3405d822, A5, 32'h8642a477, A5, 32'hbda255b3, A5,
                32'h2aadbce4, A5, 32'hbda0b3f7, A5, 32'he36c9da7, A5, 32'hdeadbeef, A5};
        h512 = {64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2,
                64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

        reset = 1'b0; capture = 1'b0; dout_ready = 1'b1; sha_type = 2'b00; h_in = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b1;
        tick();

        // SHA-256, ready held high
        exp_w = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3,
                  32'h96177a9c, 32'hb410ff61, 32'hf20015ad, 0, 0, 0, 0, 0, 0, 0, 0};
        load(h256, 2'b01);
        run_stream(0, 8, 8, 0);

        // SHA-224
        exp_w = '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3, 32'h2aadbce4,
                  32'hbda0b3f7, 32'he36c9da7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load(h224, 2'b00);
        run_stream(0, 7, 7, 0);

        // SHA-512 with stalls
        exp_w = '{32'hddaf35a1, 32'h93617aba, 32'hcc417349, 32'hae204131, 32'h12e6fa4e,
                  32'h89a97ea2, 32'h0a9eeee6, 32'h4b55d39a, 32'h2192992a, 32'h274fc1a8,
                  32'h36ba3c23, 32'ha3feebbd, 32'h454d4423, 32'h643ce80e, 32'h2a9ac94f,
                  32'ha54ca49f};
        load(h512, 2'b11);
        run_stream(0, 16, 16, 1);

        // SHA-384: first 12 words of the same bank
        load(h512, 2'b10);
        run_stream(0, 12, 12, 1);

        // Capture during word 3 of SHA-256 is dropped
        exp_w = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3,
                  32'h96177a9c, 32'hb410ff61, 32'hf20015ad, 0, 0, 0, 0, 0, 0, 0, 0};
        load(h256, 2'b01);
        run_stream(0, 3, 8, 0);
        dout_ready = 1'b0;
        h_in = h224; sha_type = 2'b00; capture = 1'b1;
        tick();
        capture = 1'b0;
        check("ovr_pulse", overrun, 1);
        check("ovr_word3", dout, 32'h5dae2223);
        tick();
        check("ovr_end", overrun, 0);
        run_stream(3, 8, 8, 0);

        // Capture coincident with the final handshake
        load(h256, 2'b01);
        run_stream(0, 7, 8, 0);
        check("b2b_last", dout_last, 1);
        check("b2b_oldw7", dout, 32'hf20015ad);
        h_in = h224; sha_type = 2'b00; capture = 1'b1; dout_ready = 1'b1;
        tick();
        capture = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_valid", dout_valid, 1);
        check("b2b_ovr", overrun, 0);
        check("b2b_new0", dout, 32'h23097d22);
        exp_w = '{32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3, 32'h2aadbce4,
                  32'hbda0b3f7, 32'he36c9da7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_stream(0, 7, 7, 0);

        // Reset at word 5 of SHA-512
        exp_w = '{32'hddaf35a1, 32'h93617aba, 32'hcc417349, 32'hae204131, 32'h12e6fa4e,
                  32'h89a97ea2, 32'h0a9eeee6, 32'h4b55d39a, 32'h2192992a, 32'h274fc1a8,
                  32'h36ba3c23, 32'ha3feebbd, 32'h454d4423, 32'h643ce80e, 32'h2a9ac94f,
                  32'ha54ca49f};
        load(h512, 2'b11);
        run_stream(0, 5, 16, 1);
        check("pre_rst_w5", dout, 32'h89a97ea2);
        reset = 1'b0;
        tick();
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_last", dout_last, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b1;
        tick();
        check("post_rst_done", done, 0);
        check("post_rst_valid", dout_valid, 0);
        load(h512, 2'b11);
        run_stream(0, 16, 16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/digest_stream.md
Name: digest_stream

Overview:
- Reads the final hash state produced by the hash update stage and emits the message digest as a stream of 32-bit words over a valid/ready handshake.
- Truncates the digest according to the SHA variant and emits words big-endian, H0 first.
- Sits between the hash core and the host/output interface; it is the consumer of the H register bank.

Parameters:
OUT_W, 32, output word width in bits; 32 is the only supported value.

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 resets on posedge clk)
sha_type  input  2  00=SHA-224, 01=SHA-256, 10=SHA-384, 11=SHA-512; sampled on accepted capture
h_in  input  512  flattened H[0..7]; H[i] at bits [511-64i -: 64]; 32-bit modes use upper half of each lane
capture  input  1  single-cycle pulse: h_in holds the final digest
busy  output  1  high while a digest is held and not fully sent
dout  output  32  digest word
dout_valid  output  1  dout is valid
dout_ready  input  1  sink accepts dout
dout_last  output  1  high with the final word of the digest
done  output  1  one-cycle pulse after the last word handshake
overrun  output  1  one-cycle pulse when a capture is dropped

Behaviour:
- Reset values: busy=0, dout=0, dout_valid=0, dout_last=0, done=0, overrun=0; FSM=IDLE; word index=0.
- Reset mid-stream aborts the transfer. Outputs take their reset values on that edge, and no done pulse is generated.
- Word counts (N):
  - SHA-224: N=7.
  - SHA-256: N=8.
  - SHA-384: N=12.
  - SHA-512: N=16.
- Word selection, 32-bit modes: word k = H[k][63:32].
- Word selection, 64-bit modes: word k = H[k>>1][63:32] when k is even, H[k>>1][31:0] when k is odd.
- FSM states:
  - IDLE: dout_valid=0. On capture=1, latch h_in and sha_type into internal registers, set index=0, and go to STREAM. dout_valid=1 from the next cycle (1-cycle latency).
  - STREAM: dout_valid=1 and dout=word[index]. A handshake occurs when dout_valid && dout_ready. On handshake with index<N-1, index increments.
  - STREAM, final word: on handshake with index==N-1 (dout_last=1), go to IDLE and pulse done in the following cycle.
- Handshake rules:
  - dout and dout_last stay stable while dout_valid && !dout_ready.
  - dout_valid never deasserts without a handshake, except on reset.
  - dout_ready may toggle arbitrarily; the block does not depend on it combinationally except for the handshake.
- Simultaneous capture and last handshake in the same cycle: capture is accepted. The FSM stays in STREAM, index=0, the new digest is latched, dout_valid stays 1 continuously, and done still pulses for the old digest.
- Capture in STREAM without a last handshake: capture is ignored, the latched data is untouched, and overrun pulses for 1 cycle.
- busy = (state==STREAM).
- h_in and sha_type are ignored outside accepted captures. Changing them mid-stream has no effect.
- dout in IDLE holds its last value, except after reset, when it is 0.

Test Plan:
1. SHA-256 "abc": capture with H[i][63:32] = ba7816bf,8f01cfea,414140de,5dae2223,b00361a3,96177a9c,b410ff61,f20015ad, lower halves = a5a5a5a5, dout_ready=1 -> 8 words in that order on consecutive cycles; dout_last on the 8th; done 1 cycle later; no a5a5a5a5 emitted.
2. SHA-224 "abc": H uppers 23097d22,3405d822,8642a477,bda255b3,2aadbce4,bda0b3f7,e36c9da7,deadbeef -> exactly 7 words; dout_last on e36c9da7; deadbeef never appears.
3. SHA-512 "abc": H = ddaf35a193617aba, cc417349ae204131, 12e6fa4e89a97ea2, 0a9eeee64b55d39a, 2192992a274fc1a8, 36ba3c23a3feebbd, 454d4423643ce80e, 2a9ac94fa54ca49f, with random dout_ready -> 16 words ddaf35a1,93617aba,...,a54ca49f; dout stable during stalls; dout_last only on a54ca49f.
4. SHA-384: same H as scenario 3, sha_type=10 -> 12 words, ending 36ba3c23,a3feebbd with dout_last; done pulses once.
5. Capture during SHA-256 word 3 (no last handshake) -> overrun pulses 1 cycle; stream completes with the original 8 words. Capture on the same cycle as the final handshake -> dout_valid uninterrupted; the next word is word 0 of the new digest.
6. reset=0 asserted at word 5 of a SHA-512 stream -> next cycle dout_valid=0, busy=0, no done. A new capture after release streams from word 0.
